mips_cpu_muldiv: RTL and testbench

Iterative multi-cycle multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits directly upstream of the ALU's Hi/Lo special registers. Its `hi`/`lo` results drive the ALU `Hi_in`/`Lo_in` inputs. Its `done` pulse drives `SpcRegWriteEn`, so Hi/Lo are written once per completed operation. The single-cycle combinational `*`, `/` and `%` are replaced by a 32-iteration shift-add / restoring-divide datapath, with `busy` driving a pipeline stall.

---
 rtl/mips_cpu_muldiv.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv
//
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It feeds the
// ALU Hi/Lo special registers: hi/lo drive Hi_in/Lo_in, done drives the Hi/Lo
// write enable, and busy drives the pipeline stall.
//
// The datapath runs one shift-add (multiply) or restoring-divide step per
// cycle on operand magnitudes. A single FIXUP cycle then applies the recorded
// signs and registers the result.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a new operation (sampled only in IDLE)
//   op[1:0]   in   0=MULT 1=MULTU 2=DIV 3=DIVU
//   a         in   rs operand (multiplicand / dividend)
//   b         in   rt operand (multiplier / divisor)
//   flush     in   synchronous abort of an in-flight operation
//   busy      out  operation in flight (pipeline stall request)
//   done      out  one-cycle pulse, hi/lo valid (Hi/Lo write enable)
//   hi        out  product upper half, or remainder
//   lo        out  product lower half, or quotient
//   div_zero  out  high with done when a divide had a zero divisor
//
// Handshake: start is accepted only when busy=0 and flush=0. busy covers
// the interval from the accepting edge up to the edge that raises done.
// done is high for exactly one cycle, and busy is already low in that cycle.
// A start while busy=1 is dropped, not queued.
//
// Optional build macro: MULDIV_EARLY_TERM_EN. When it is defined, a
// multiply whose remaining multiplier bits are all zero finishes its shifting
// in one step. Results are identical in both builds.
// ---------------------------------------------------------------------------
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]  cnt, cnt_next;
  logic           is_mul, is_mul_next;
  logic           neg_hi, neg_hi_next;     // negate upper result half / remainder
  logic           neg_lo, neg_lo_next;     // negate product / quotient
  logic           dz, dz_next;             // divisor was zero
  logic [W-1:0]   opd, opd_next;           // multiplicand or divisor magnitude
  logic [2*W-1:0] acc, acc_next;           // {upper, multiplier} or {rem, quot}
  logic [W-1:0]   hi_next, lo_next;
  logic           done_next, div_zero_next;

  // Operand magnitudes. Only the signed ops (op[0]=0) take absolute values.
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  assign a_neg = ~op[0] & a[W-1];
  assign b_neg = ~op[0] & b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Shift-add step. The carry out of the upper-half add becomes the new MSB
  // when the whole accumulator shifts right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;

  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : {(W+1){1'b0}});
  assign mul_step = {mul_sum, acc[W-1:1]};

  // Restoring-divide step. The shifted partial remainder is W+1 bits wide so
  // that the trial subtraction is an unsigned (W+1)-bit compare.
  logic [W:0]     div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_step;

  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, opd};
  assign div_ge    = (div_shift >= {1'b0, opd});
  assign div_step  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ge};

`ifdef MULDIV_EARLY_TERM_EN
  // After this step, (W-1-cnt) multiplier bits are still unshifted in the
  // low end of the accumulator. If they are all zero, the remaining
  // iterations would only shift, so they are done at once.
  logic [CW-1:0] rem_cnt;
  logic [W-1:0]  rem_mask;

  assign rem_cnt  = CW'(W - 1) - cnt;
  assign rem_mask = ~({W{1'b1}} << rem_cnt);
`endif

  // Sign fixup. With a zero divisor the remainder path already holds |a|, so
  // negating it by the dividend sign returns the raw a. Only the quotient
  // needs overriding.
  logic [2*W-1:0] mul_res;
  logic [W-1:0]   quo_res, rem_res;

  assign mul_res = neg_lo ? -acc : acc;
  assign quo_res = dz ? {W{1'b1}} : (neg_lo ? -acc[W-1:0] : acc[W-1:0]);
  assign rem_res = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];

  assign busy = (state != S_IDLE);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    is_mul_next   = is_mul;
    neg_hi_next   = neg_hi;
    neg_lo_next   = neg_lo;
    dz_next       = dz;
    opd_next      = opd;
    acc_next      = acc;
    hi_next       = hi;
    lo_next       = lo;
    done_next     = 1'b0;
    div_zero_next = 1'b0;

    case (state)
      S_IDLE: begin
        // flush in IDLE suppresses a same-cycle start.
        if (start && !flush) begin
          state_next  = S_CALC;
          cnt_next    = '0;
          is_mul_next = ~op[1];
          opd_next    = op[1] ? b_mag : a_mag;
          acc_next    = {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
          neg_lo_next = a_neg ^ b_neg;
          neg_hi_next = op[1] ? a_neg : (a_neg ^ b_neg);
          dz_next     = op[1] & (b == '0);
        end
      end

      S_CALC: begin
        if (flush) begin
          state_next = S_IDLE;
        end else begin
          if (is_mul) begin
            acc_next = mul_step;
          end else begin
            acc_next = div_step;
          end

          if (cnt == CW'(W - 1)) begin
            state_next = S_FIXUP;
          end else begin
            cnt_next = cnt + 1'b1;
          end

`ifdef MULDIV_EARLY_TERM_EN
          if (is_mul && ((mul_step[W-1:0] & rem_mask) == '0)) begin
            acc_next   = mul_step >> rem_cnt;
            state_next = S_FIXUP;
          end
`endif
        end
      end

      S_FIXUP: begin
        state_next = S_IDLE;
        if (!flush) begin
          if (is_mul) begin
            hi_next = mul_res[2*W-1:W];
            lo_next = mul_res[W-1:0];
          end else begin
            hi_next = rem_res;
            lo_next = quo_res;
          end
          done_next     = 1'b1;
          div_zero_next = dz;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_mul   <= 1'b0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
      dz       <= 1'b0;
      opd      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      is_mul   <= is_mul_next;
      neg_hi   <= neg_hi_next;
      neg_lo   <= neg_lo_next;
      dz       <= dz_next;
      opd      <= opd_next;
      acc      <= acc_next;
      hi       <= hi_next;
      lo       <= lo_next;
      done     <= done_next;
      div_zero <= div_zero_next;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv
//
// Directed and random operations on mips_cpu_muldiv. Expected hi/lo, latency
// and div_zero come from a reference model written with plain arithmetic.
// The bench covers reset, flush, the ignored start while busy, and an
// asynchronous reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_mips_cpu_muldiv;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---- clock / reset -------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  always #5 clk = ~clk;

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // ---- scoreboard ----------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  // Returns {div_zero, hi, lo}.
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin
        p = 64'(sx * sy);
        return {1'b0, p};
      end
      2'd1: begin
        p = {32'b0, x} * {32'b0, y};
        return {1'b0, p};
      end
      2'd2: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        q = 32'(sx / sy);
        r = 32'(sx % sy);
        return {1'b0, r, q};
      end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        q = x / y;
        r = x % y;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Number of edges after the accepting edge until done is seen.
  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] m;
    int          k;
    m = (!o[0] && y[31]) ? -y : y;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    if (EARLY && !o[1]) return k + 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---- driver --------------------------------------------------------------
  // Issues one operation and checks result, latency, busy span and the
  // one-cycle done/div_zero pulse. When inject is set, a second start is
  // raised mid-operation; it must be dropped.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, input string tag);
    logic [64:0] r;
    logic [63:0] e;
    int          lat;
    int          bcnt;
    int          n;
    r   = ref_model(o, x, y);
    lat = exp_latency(o, y);
    exp_q.push_back(r[63:0]);

    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operand changes while busy must not matter.
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    bcnt  = busy ? 1 : 0;
    n     = 0;
    while (!done && n < 100) begin
      start = (inject && n == 4) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (busy) bcnt++;
    end
    start = 1'b0;

    e = exp_q.pop_front();
    check({tag, "_latency"},  64'(n),    64'(lat));
    check({tag, "_busy_cyc"}, 64'(bcnt), 64'(lat));
    check({tag, "_hi"},       64'(hi),   64'(e[63:32]));
    check({tag, "_lo"},       64'(lo),   64'(e[31:0]));
    check({tag, "_divzero"},  64'(div_zero), 64'(r[64]));

    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'({done, div_zero, busy}), 64'd0);
    check({tag, "_hold"},       {hi, lo}, e);
  endtask

  // ---- directed sequence ---------------------------------------------------
  initial begin
    logic [31:0] hi_prev;
    logic [31:0] lo_prev;
    int          done_seen;
    logic [1:0]  ro;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_outputs", 64'({busy, done, div_zero}), 64'd0);
    check("reset_hilo",    {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
    check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    run_op(2'd0, 32'd5, 32'd1, 1'b0, "mult_b1");
    run_op(2'd1, 32'h1234_5678, 32'd0, 1'b0, "multu_b0");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    check("div_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, "divu");
    run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0, "divu_zero");
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, "div_zero_neg");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf_inject");
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_negdiv");

    // Flush at E10 of a MULT: no done, hi/lo keep the prior result.
    hi_prev = hi;
    lo_prev = lo;
    @(negedge clk);
    op    = 2'd0;
    a     = 32'h1357_9BDF;
    b     = 32'h7FFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hilo", {hi, lo}, {hi_prev, lo_prev});

    // flush in IDLE wins over start.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("idle_flush_start", 64'(busy), 64'd0);

    // Asynchronous reset in mid-CALC.
    @(negedge clk);
    op    = 2'd3;
    a     = 32'hDEAD_BEEF;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl",  64'({busy, done, div_zero}), 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd3, 32'hDEAD_BEEF, 32'd3, 1'b0, "after_reset");

    // Random operations against the model.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, rand_opnd(), rand_opnd(), 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so a stuck DUT can never hang the run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
